// File: rtl/clock_time_controller_pkg.sv
// Shared definitions for the clock timekeeping/time-set controller: mode
// encodings, field limits and blank-mask digit positions.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_HR  = 2'b01,
        MODE_SET_MIN = 2'b10,
        MODE_SET_SEC = 2'b11
    } mode_e;

    localparam int HR_MAX  = 23;
    localparam int MIN_MAX = 59;
    localparam int SEC_MAX = 59;

    localparam int BLANK_SEC_ONES = 0;
    localparam int BLANK_SEC_TENS = 1;
    localparam int BLANK_MIN_ONES = 2;
    localparam int BLANK_MIN_TENS = 3;
    localparam int BLANK_HR_ONES  = 4;
    localparam int BLANK_HR_TENS  = 5;

    // Digit pair belonging to the field being edited; empty in RUN.
    function automatic logic [5:0] blank_mask(input mode_e m);
        logic [5:0] mask;
        mask = '0;
        case (m)
            MODE_SET_HR: begin
                mask[BLANK_HR_ONES] = 1'b1;
                mask[BLANK_HR_TENS] = 1'b1;
            end
            MODE_SET_MIN: begin
                mask[BLANK_MIN_ONES] = 1'b1;
                mask[BLANK_MIN_TENS] = 1'b1;
            end
            MODE_SET_SEC: begin
                mask[BLANK_SEC_ONES] = 1'b1;
                mask[BLANK_SEC_TENS] = 1'b1;
            end
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/clock_time_controller_if.sv
// Bundle of the clock controller's button inputs and display-side outputs.
interface clock_time_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
    logic [5:0] blank;
    logic [1:0] mode;
    logic       scan_en;

    modport master (
        output btn_mode, btn_inc,
        input  hr, min, sec, blank, mode, scan_en
    );

    modport slave (
        input  btn_mode, btn_inc,
        output hr, min, sec, blank, mode, scan_en
    );
endinterface

// File: rtl/clock_time_controller_btn_debounce.sv
// Push-button front end: 2-flop synchronizer, debounce filter and a
// one-cycle press pulse on each accepted rising level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic             deb_prev_q, deb_prev_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d    = btn_raw;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        cnt_d      = '0;
        // Any cycle where synced level matches the accepted level restarts the count.
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = deb_q & ~deb_prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            press_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            press_q    <= press_d;
            cnt_q      <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/clock_time_controller.sv
// 24-hour timekeeper with button-driven set mode, edit-field blink mask
// and free-running digit scan strobe.
module clock_time_controller
    import clock_ctrl_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 25_000_000,
    parameter int SCAN_DIV        = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hr,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [5:0] blank,
    output logic [1:0] mode,
    output logic       scan_en
);

    localparam int PRESC_W = $clog2(CLK_HZ + 1);
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
    localparam int SCAN_W  = $clog2(SCAN_DIV + 1);

    logic mode_press, inc_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_mode),
        .press  (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_btn (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_inc),
        .press  (inc_press)
    );

    mode_e              mode_q, mode_d;
    logic [4:0]         hr_q, hr_d;
    logic [5:0]         min_q, min_d;
    logic [5:0]         sec_q, sec_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [5:0]         blank_q, blank_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic               scan_en_q, scan_en_d;
    logic               tick;
    logic               inc_accept;

    always_comb begin
        mode_d        = mode_q;
        hr_d          = hr_q;
        min_d         = min_q;
        sec_d         = sec_q;
        presc_d       = '0;
        blink_cnt_d   = '0;
        blink_phase_d = 1'b0;
        scan_cnt_d    = scan_cnt_q + 1'b1;
        scan_en_d     = 1'b0;

        tick       = (mode_q == MODE_RUN) && (presc_q == PRESC_W'(CLK_HZ - 1));
        inc_accept = inc_press && !mode_press && (mode_q != MODE_RUN);

        if ((mode_q == MODE_RUN) && !tick) begin
            presc_d = presc_q + 1'b1;
        end

        if (tick) begin
            if (sec_q == 6'(SEC_MAX)) begin
                sec_d = '0;
                if (min_q == 6'(MIN_MAX)) begin
                    min_d = '0;
                    hr_d  = (hr_q == 5'(HR_MAX)) ? '0 : hr_q + 1'b1;
                end else begin
                    min_d = min_q + 1'b1;
                end
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end

        // A mode press in the same cycle as an inc press discards the inc.
        if (mode_press) begin
            case (mode_q)
                MODE_RUN:     mode_d = MODE_SET_HR;
                MODE_SET_HR:  mode_d = MODE_SET_MIN;
                MODE_SET_MIN: mode_d = MODE_SET_SEC;
                default:      mode_d = MODE_RUN;
            endcase
        end else if (inc_accept) begin
            case (mode_q)
                MODE_SET_HR:  hr_d  = (hr_q  == 5'(HR_MAX))  ? '0 : hr_q  + 1'b1;
                MODE_SET_MIN: min_d = (min_q == 6'(MIN_MAX)) ? '0 : min_q + 1'b1;
                MODE_SET_SEC: sec_d = (sec_q == 6'(SEC_MAX)) ? '0 : sec_q + 1'b1;
                default:      hr_d  = hr_q;
            endcase
        end

        if (!(mode_press || inc_accept || (mode_q == MODE_RUN))) begin
            if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + 1'b1;
                blink_phase_d = blink_phase_q;
            end
        end

        // Built from next-state values so blank updates together with mode/phase.
        blank_d = blink_phase_d ? blank_mask(mode_d) : '0;

        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            scan_en_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q        <= MODE_RUN;
            hr_q          <= '0;
            min_q         <= '0;
            sec_q         <= '0;
            presc_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            blank_q       <= '0;
            scan_cnt_q    <= '0;
            scan_en_q     <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            hr_q          <= hr_d;
            min_q         <= min_d;
            sec_q         <= sec_d;
            presc_q       <= presc_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            blank_q       <= blank_d;
            scan_cnt_q    <= scan_cnt_d;
            scan_en_q     <= scan_en_d;
        end
    end

    assign hr      = hr_q;
    assign min     = min_q;
    assign sec     = sec_q;
    assign blank   = blank_q;
    assign mode    = mode_q;
    assign scan_en = scan_en_q;

endmodule

// File: tb/tb_clock_time_controller.sv
// Scoreboard bench: a time-of-day reference model predicts every cycle's
// outputs into a queue; a negedge monitor pops and compares them.
module tb_clock_time_controller;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;
  localparam int BLINK  = 8;
  localparam int SCAN   = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  clock_time_if bus ();

  always #5 clk = ~clk;

  clock_time_controller #(
    .CLK_HZ         (CLK_HZ),
    .DEBOUNCE_CYCLES(DEB),
    .BLINK_CYCLES   (BLINK),
    .SCAN_DIV       (SCAN)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_mode(bus.btn_mode),
    .btn_inc (bus.btn_inc),
    .hr      (bus.hr),
    .min     (bus.min),
    .sec     (bus.sec),
    .blank   (bus.blank),
    .mode    (bus.mode),
    .scan_en (bus.scan_en)
  );

  typedef struct packed {
    logic [4:0] hr;
    logic [5:0] mi;
    logic [5:0] se;
    logic [5:0] blank;
    logic [1:0] mode;
    logic       scan;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  int m_t, m_mode, m_run, m_blink, m_scan, m_cyc;
  bit m_deb[2];
  int m_diff[2];
  int due_mode[$];
  int due_inc[$];

  initial begin
    m_t = 0; m_mode = 0; m_run = 0; m_blink = 0; m_scan = 0; m_cyc = 0;
    m_deb[0] = 0; m_deb[1] = 0; m_diff[0] = 0; m_diff[1] = 0;
  end

  always @(posedge clk) begin
    obs_t e;
    bit   raw[2];
    bit   mp, ip, tick;
    int   h, mi, s;
    m_cyc++;
    if (reset) begin
      m_t = 0; m_mode = 0; m_run = 0; m_blink = 0; m_scan = 0;
      m_deb[0] = 0; m_deb[1] = 0; m_diff[0] = 0; m_diff[1] = 0;
      due_mode.delete();
      due_inc.delete();
    end else begin
      raw[0] = bus.btn_mode;
      raw[1] = bus.btn_inc;
      for (int unsigned b = 0; b < 2; b++) begin
        if (raw[b] != m_deb[b]) begin
          m_diff[b]++;
          if (m_diff[b] == DEB) begin
            m_deb[b]  = raw[b];
            m_diff[b] = 0;
            if (raw[b]) begin
              if (b == 0) due_mode.push_back(m_cyc + 4);
              else        due_inc.push_back(m_cyc + 4);
            end
          end
        end else begin
          m_diff[b] = 0;
        end
      end
      mp = 0;
      ip = 0;
      if (due_mode.size() > 0 && due_mode[0] == m_cyc) begin
        mp = 1;
        void'(due_mode.pop_front());
      end
      if (due_inc.size() > 0 && due_inc[0] == m_cyc) begin
        ip = 1;
        void'(due_inc.pop_front());
      end
      tick = 0;
      if (m_mode == 0) begin
        m_run++;
        if (m_run == CLK_HZ) begin
          tick  = 1;
          m_run = 0;
        end
      end
      if (tick) m_t = (m_t + 1) % 86400;
      if (mp) begin
        m_mode  = (m_mode + 1) % 4;
        m_run   = 0;
        m_blink = 0;
      end else if (ip && m_mode != 0) begin
        h  = m_t / 3600;
        mi = (m_t / 60) % 60;
        s  = m_t % 60;
        if (m_mode == 1)      h  = (h + 1) % 24;
        else if (m_mode == 2) mi = (mi + 1) % 60;
        else                  s  = (s + 1) % 60;
        m_t     = h * 3600 + mi * 60 + s;
        m_blink = 0;
      end else if (m_mode != 0) begin
        m_blink++;
      end
      m_scan++;
    end
    e.hr    = 5'(m_t / 3600);
    e.mi    = 6'((m_t / 60) % 60);
    e.se    = 6'(m_t % 60);
    e.mode  = 2'(m_mode);
    e.scan  = (m_scan > 0) && (m_scan % SCAN == 0);
    e.blank = 6'b000000;
    if (((m_blink / BLINK) % 2) == 1) begin
      case (m_mode)
        1:       e.blank = 6'b110000;
        2:       e.blank = 6'b001100;
        3:       e.blank = 6'b000011;
        default: e.blank = 6'b000000;
      endcase
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.hr    = bus.hr;
      a.mi    = bus.min;
      a.se    = bus.sec;
      a.blank = bus.blank;
      a.mode  = bus.mode;
      a.scan  = bus.scan_en;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: got %0d:%0d:%0d blank=%b mode=%0d scan=%b, expected %0d:%0d:%0d blank=%b mode=%0d scan=%b",
                 $time, a.hr, a.mi, a.se, a.blank, a.mode, a.scan,
                 e.hr, e.mi, e.se, e.blank, e.mode, e.scan);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input bit m, input bit i, input int hold, input int gap);
    bus.btn_mode = m;
    bus.btn_inc  = i;
    step(hold);
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    step(gap);
  endtask

  task automatic check_reset(input string tag);
    checks++;
    if (bus.hr !== '0 || bus.min !== '0 || bus.sec !== '0 || bus.blank !== '0 ||
        bus.mode !== 2'b00 || bus.scan_en !== 1'b0) begin
      errors++;
      $display("FAIL reset state (%s) t=%0t: %0d:%0d:%0d blank=%b mode=%0d scan=%b",
               tag, $time, bus.hr, bus.min, bus.sec, bus.blank, bus.mode, bus.scan_en);
    end
  endtask

  task automatic wait_mode(input logic [1:0] target, input int max_cycles);
    int n;
    n = 0;
    while (bus.mode !== target && n < max_cycles) begin
      step(1);
      n++;
    end
    checks++;
    if (bus.mode !== target) begin
      errors++;
      $display("FAIL wait expired t=%0t: mode=%0d never reached %0d within %0d cycles",
               $time, bus.mode, target, max_cycles);
    end
  endtask

  initial begin
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    reset = 1'b1;
    step(3);
    check_reset("initial");
    reset = 1'b0;
    step(605);

    reset = 1'b1;
    bus.btn_mode = 1'b1;
    step(2);
    reset = 1'b0;
    step(6);
    bus.btn_mode = 1'b0;
    step(10);
    repeat (25) press(1'b0, 1'b1, 5, 5);
    repeat (22) press(1'b0, 1'b1, 5, 5);
    press(1'b1, 1'b0, 5, 5);
    step(40);
    repeat (59) press(1'b0, 1'b1, 5, 5);
    press(1'b1, 1'b0, 5, 5);
    repeat (55) press(1'b0, 1'b1, 5, 5);
    step(20);
    press(1'b1, 1'b0, 5, 5);
    step(120);

    press(1'b1, 1'b0, 5, 5);
    press(1'b1, 1'b1, 5, 5);
    press(1'b0, 1'b1, 2, 10);
    press(1'b1, 1'b0, 5, 5);
    press(1'b1, 1'b0, 5, 5);
    step(30);

    repeat (300) begin
      case ($urandom_range(0, 3))
        0:       step($urandom_range(1, 30));
        1:       press(1'b1, 1'b0, $urandom_range(1, 8), $urandom_range(1, 10));
        2:       press(1'b0, 1'b1, $urandom_range(1, 8), $urandom_range(1, 10));
        default: press(1'b1, 1'b1, $urandom_range(1, 8), $urandom_range(1, 10));
      endcase
    end

    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);
    repeat (3) press(1'b1, 1'b0, 5, 5);
    wait_mode(2'b11, 20);
    step(12);
    reset = 1'b1;
    step(1);
    check_reset("set_sec mid-blink");
    reset = 1'b0;
    step(20);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
